// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types, requester indices and pointer-wrap helper for cdb_arbiter.
package cdb_arbiter_pkg;

   localparam int ROB_WIDTH = 6;
   localparam int N_CDB_REQ = 4;

   typedef struct packed {
      logic                 valid;
      logic [ROB_WIDTH-1:0] tag;
      logic [31:0]          data;
   } cdb_t;

   typedef enum logic [1:0] {
      CDB_REQ_LWSW = 2'd0,
      CDB_REQ_ALU  = 2'd1,
      CDB_REQ_FPU  = 2'd2,
      CDB_REQ_BR   = 2'd3
   } cdb_req_e;

   // Next round-robin start after a grant to g; explicit compare so non-power-of-two N wraps.
   function automatic int next_ptr(input int g, input int n, input int lo);
      return (g == n - 1) ? lo : g + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester/broadcast bundle between execution units and one CDB arbiter.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ = N_CDB_REQ
) ();

   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_ready;
   cdb_t [N_REQ-1:0] req_result;
   logic             flush;
   cdb_t             cdb;

   modport master (output req_valid, req_result, flush, input req_ready, cdb);
   modport slave  (input req_valid, req_result, flush, output req_ready, cdb);

endinterface

// File: rtl/cdb_arbiter_chk.sv
// Simulation invariants for cdb_arbiter: one-hot grants, broadcasts only follow a fire.
module cdb_arbiter_chk #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input logic             clk,
   input logic             reset,
   input logic [N_REQ-1:0] req_valid_i,
   input logic [N_REQ-1:0] req_ready_i,
   input logic             gnt_v_i,
   input logic [IDX_W-1:0] gnt_idx_i
);

   logic [N_REQ-1:0] fire_q;

   // Remember which requester actually fired last cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fire_q <= '0;
      end else begin
         fire_q <= req_valid_i & req_ready_i;
      end
   end

   a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready_i));
   a_bcast_after_fire: assert property (@(posedge clk) disable iff (!reset) gnt_v_i |-> fire_q[gnt_idx_i]);

endmodule

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational rotating priority encoder: first set bit of req_i at or after start_i.
module cdb_arbiter_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic             any_o,
   output logic [IDX_W-1:0] idx_o,
   output logic [N-1:0]     onehot_o
);

   // Walk offsets from farthest to nearest so the nearest requester is assigned last and wins.
   always_comb begin
      any_o    = 1'b0;
      idx_o    = '0;
      onehot_o = '0;
      for (int off = N - 1; off >= 0; off--) begin
         int pos;
         pos = (int'(start_i) + off >= N) ? int'(start_i) + off - N : int'(start_i) + off;
         if (req_i[pos]) begin
            any_o = 1'b1;
            idx_o = IDX_W'(pos);
         end else begin
            any_o = any_o;
         end
      end
      onehot_o = any_o ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for one common data bus; grant at t, broadcast of the winner at t+1.
// Optional CDB_ARB_PRIO0_EN: requester 0 (lw_sw) always wins, round-robin among 1..N_REQ-1.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ = N_CDB_REQ,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic            clk,
   input  logic            reset,
   cdb_arbiter_if.slave    bus,
   output logic [IDX_W:0]  grant_count_q
);

   logic [IDX_W-1:0] rr_q;
   logic [IDX_W-1:0] rr_d;
   logic             gnt_v_q;
   logic [IDX_W-1:0] gnt_idx_q;

   logic [N_REQ-1:0] pick_req_s;
   logic             pick_any_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic [N_REQ-1:0] pick_onehot_s;
   logic             gnt_any_s;
   logic [IDX_W-1:0] gnt_idx_s;
   logic [N_REQ-1:0] gnt_oh_s;
   logic             fire_s;

   // Requester 0 is removed from the rotation when it has fixed priority.
   always_comb begin
      pick_req_s = bus.req_valid;
`ifdef CDB_ARB_PRIO0_EN
      pick_req_s[int'(CDB_REQ_LWSW)] = 1'b0;
`endif
   end

   cdb_arbiter_rr_picker #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i    (pick_req_s),
      .start_i  (rr_q),
      .any_o    (pick_any_s),
      .idx_o    (pick_idx_s),
      .onehot_o (pick_onehot_s)
   );

   // Select the winner, gate it with flush/reset and compute the next rotation start.
   always_comb begin
`ifdef CDB_ARB_PRIO0_EN
      if (bus.req_valid[int'(CDB_REQ_LWSW)]) begin
         gnt_any_s = 1'b1;
         gnt_idx_s = '0;
         gnt_oh_s  = N_REQ'(1);
      end else begin
         gnt_any_s = pick_any_s;
         gnt_idx_s = pick_idx_s;
         gnt_oh_s  = pick_onehot_s;
      end
`else
      gnt_any_s = pick_any_s;
      gnt_idx_s = pick_idx_s;
      gnt_oh_s  = pick_onehot_s;
`endif
      fire_s        = gnt_any_s && !bus.flush && reset;
      bus.req_ready = fire_s ? gnt_oh_s : '0;
`ifdef CDB_ARB_PRIO0_EN
      if (fire_s && (gnt_idx_s != '0)) begin
         rr_d = IDX_W'(next_ptr(int'(gnt_idx_s), N_REQ, 1));
      end else begin
         rr_d = rr_q;
      end
`else
      if (fire_s) begin
         rr_d = IDX_W'(next_ptr(int'(gnt_idx_s), N_REQ, 0));
      end else begin
         rr_d = rr_q;
      end
`endif
   end

   // Broadcast the result of last cycle's winner unless flushed; bus is zeroed when idle.
   always_comb begin
      if (gnt_v_q && !bus.flush) begin
         bus.cdb       = bus.req_result[gnt_idx_q];
         bus.cdb.valid = 1'b1;
      end else begin
         bus.cdb = '0;
      end
   end

   // Rotation pointer and grant pipeline register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q          <= '0;
         gnt_v_q       <= 1'b0;
         gnt_idx_q     <= '0;
         grant_count_q <= '0;
      end else begin
         rr_q          <= rr_d;
         gnt_v_q       <= fire_s;
         gnt_idx_q     <= gnt_idx_s;
         grant_count_q <= {{IDX_W{1'b0}}, fire_s};
      end
   end

   cdb_arbiter_chk #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_chk (
      .clk         (clk),
      .reset       (reset),
      .req_valid_i (bus.req_valid),
      .req_ready_i (bus.req_ready),
      .gnt_v_i     (gnt_v_q),
      .gnt_idx_i   (gnt_idx_q)
   );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised scoreboard bench for cdb_arbiter against a round-robin reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [IW:0]   grant_count_q;

   cdb_arbiter_if #(.N_REQ(N)) bus();

   cdb_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .grant_count_q (grant_count_q)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0]     v;
      logic             f;
      cdb_t [N-1:0]     res;
   } stim_t;

   typedef struct {
      int                   cyc;
      logic [ROB_WIDTH-1:0] tag;
      logic [31:0]          data;
   } exp_t;

   stim_t plan_q[$];
   exp_t  sb_q[$];
   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   int    m_ptr = 0;
   bit    prev_fire = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic stim_t mk(input logic [N-1:0] v, input logic f);
      stim_t s;
      s.v = v;
      s.f = f;
      for (int i = 0; i < N; i++) begin
         s.res[i].valid = 1'b1;
         s.res[i].tag   = ROB_WIDTH'($urandom);
         s.res[i].data  = $urandom;
      end
      return s;
   endfunction

   task automatic add(input logic [N-1:0] v, input logic f, input int n);
      repeat (n) plan_q.push_back(mk(v, f));
   endtask

   // Reference: nearest valid requester at or after the pointer, going around the ring.
   function automatic int model_grant(input logic [N-1:0] v, input logic f);
      if (f) return -1;
`ifdef CDB_ARB_PRIO0_EN
      if (v[0]) return 0;
`endif
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
`ifdef CDB_ARB_PRIO0_EN
         if (i == 0) continue;
`endif
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic step();
      stim_t        cur;
      stim_t        nxt;
      int           g;
      logic [N-1:0] er;
      @(posedge clk);
      #1;
      cur = plan_q.pop_front();
      if (plan_q.size() == 0) plan_q.push_back(mk('0, 1'b0));
      nxt = plan_q[0];
      bus.req_valid  = cur.v;
      bus.flush      = cur.f;
      bus.req_result = cur.res;
      @(negedge clk);
      g  = model_grant(cur.v, cur.f);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      chk("grant_count", grant_count_q, prev_fire);
      if (g >= 0) begin
`ifdef CDB_ARB_PRIO0_EN
         if (g != 0) m_ptr = g % (N - 1) + 1;
`else
         m_ptr = (g + 1) % N;
`endif
         if (!nxt.f) sb_q.push_back('{cyc + 1, nxt.res[g].tag, nxt.res[g].data});
      end
      prev_fire = (g >= 0);
   endtask

   task automatic run();
      plan_q.push_back(mk('0, 1'b0));
      while (plan_q.size() > 1) step();
   endtask

   // Monitor: every broadcast must match the oldest expectation for this exact cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (bus.cdb.valid) begin
               if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
                  tests++;
                  fails++;
                  $display("FAIL cdb_unexpected: valid broadcast at cycle %0d, none expected", cyc);
               end else begin
                  e = sb_q.pop_front();
                  chk("cdb_tag", bus.cdb.tag, e.tag);
                  chk("cdb_data", bus.cdb.data, e.data);
               end
            end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
               e = sb_q.pop_front();
               tests++;
               fails++;
               $display("FAIL cdb_missing: got no broadcast, expected tag %0h at cycle %0d", e.tag, e.cyc);
            end else begin
               chk("cdb_idle", bus.cdb, '0);
            end
         end
      end
   end

   initial begin
      stim_t s;
      bus.req_valid  = '0;
      bus.flush      = 1'b0;
      bus.req_result = '0;
      #1;
      chk("rst_ready", bus.req_ready, '0);
      chk("rst_cdb", bus.cdb, '0);
      chk("rst_gcount", grant_count_q, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      add(4'b0000, 1'b0, 10); run();
      add(4'b0101, 1'b0, 4);  run();

      add(4'b1000, 1'b0, 1);
      add(4'b0000, 1'b0, 1);
      s = plan_q[plan_q.size() - 1];
      s.res[3].tag  = ROB_WIDTH'(5);
      s.res[3].data = 32'hDEADBEEF;
      plan_q[plan_q.size() - 1] = s;
      run();

      add(4'b0001, 1'b0, 1);
      add(4'b1111, 1'b1, 1);
      add(4'b1111, 1'b0, 1);
      run();

      // Reset lands mid-cycle while the last grant is being broadcast.
      @(posedge clk);
      #1;
      s = plan_q.pop_front();
      bus.req_valid  = s.v;
      bus.flush      = s.f;
      bus.req_result = s.res;
      chk("pre_reset_cdb_valid", bus.cdb.valid, 1'b1);
      #2;
      reset = 1'b0;
      bus.req_valid = '1;
      #1;
      chk("async_rst_cdb", bus.cdb, '0);
      chk("async_rst_ready", bus.req_ready, '0);
      chk("async_rst_gcount", grant_count_q, '0);
      sb_q.delete();
      m_ptr     = 0;
      prev_fire = 1'b0;
      bus.req_valid = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      add(4'b1111, 1'b0, 3);
      add(4'b1110, 1'b0, 3);
      run();

      for (int i = 0; i < 300; i++) begin
         add(N'($urandom), ($urandom_range(0, 9) == 0), 1);
      end
      run();

      run();
      repeat (2) @(negedge clk);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
